// File: rtl/dcache_port_ctrl_if.sv
// rtl/dcache_port_ctrl_if.sv - memory-stage, walker and cache-port signals of the data-cache port
interface dcache_port_ctrl_if;
  logic        mem_req_valid;
  logic [1:0]  mem_rw;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_size;
  logic        mem_clear;
  logic        mem_stall;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        ptw_req_valid;
  logic [31:0] ptw_addr;
  logic        ptw_resp_valid;
  logic [31:0] ptw_rdata;
  logic [31:0] p_addr;
  logic        p_addr_valid;
  logic [1:0]  cache_rw;
  logic [31:0] cache_write;
  logic [3:0]  cache_wstrb;
  logic        cache_ready;
  logic [31:0] cache_read;

  // Controller side: consumes requests and cache completions, drives the port.
  modport slave (
    input  mem_req_valid, mem_rw, mem_addr, mem_wdata, mem_size, mem_clear,
    input  ptw_req_valid, ptw_addr, cache_ready, cache_read,
    output mem_stall, mem_resp_valid, mem_rdata, ptw_resp_valid, ptw_rdata,
    output p_addr, p_addr_valid, cache_rw, cache_write, cache_wstrb
  );

  // Environment side: requesters plus the cache itself.
  modport master (
    output mem_req_valid, mem_rw, mem_addr, mem_wdata, mem_size, mem_clear,
    output ptw_req_valid, ptw_addr, cache_ready, cache_read,
    input  mem_stall, mem_resp_valid, mem_rdata, ptw_resp_valid, ptw_rdata,
    input  p_addr, p_addr_valid, cache_rw, cache_write, cache_wstrb
  );
endinterface

// File: rtl/dcache_port_ctrl.sv
// rtl/dcache_port_ctrl.sv - round-robin sequencer for the shared data-cache port
module dcache_port_ctrl (
  input  logic             clk,
  input  logic             rstn,
  dcache_port_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_PTW} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_ptw;
  logic        r_drop;
  logic [31:0] r_p_addr;
  logic        r_p_addr_valid;
  logic [1:0]  r_cache_rw;
  logic [31:0] r_cache_write;
  logic [3:0]  r_cache_wstrb;
  logic [2:0]  r_size;
  logic        r_mem_resp_valid;
  logic [31:0] r_mem_rdata;
  logic        r_ptw_resp_valid;
  logic [31:0] r_ptw_rdata;

  logic        w_mem_rw_ok;
  logic        w_mem_elig;
  logic        w_ptw_elig;
  logic        w_issue_mem;
  logic        w_issue_ptw;
  logic        w_done;
  logic [31:0] w_store_data;
  logic [3:0]  w_store_strb;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  // A requester that is seeing its response pulse this cycle is stale and not eligible.
  assign w_mem_rw_ok = (bus.mem_rw == 2'b01) || (bus.mem_rw == 2'b10);
  assign w_mem_elig  = bus.mem_req_valid & w_mem_rw_ok & ~bus.mem_clear & ~r_mem_resp_valid;
  assign w_ptw_elig  = bus.ptw_req_valid & ~r_ptw_resp_valid;
  assign w_done      = (r_state != S_IDLE) & bus.cache_ready;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and grant: ties go to whoever was not served last.
  always_comb begin
    w_state_nxt = r_state;
    w_issue_mem = 1'b0;
    w_issue_ptw = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_elig && (!w_ptw_elig || r_last_ptw)) begin
          w_state_nxt = S_MEM;
          w_issue_mem = 1'b1;
        end else if (w_ptw_elig) begin
          w_state_nxt = S_PTW;
          w_issue_ptw = 1'b1;
        end
      end
      S_MEM, S_PTW: if (bus.cache_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Store data replicated across lanes; strobes select the addressed lanes, none for loads.
  always_comb begin
    w_store_data = bus.mem_wdata;
    w_store_strb = 4'b1111;
    case (bus.mem_size[1:0])
      2'b00: begin
        w_store_data = {4{bus.mem_wdata[7:0]}};
        w_store_strb = 4'b0001 << bus.mem_addr[1:0];
      end
      2'b01: begin
        w_store_data = {2{bus.mem_wdata[15:0]}};
        w_store_strb = 4'b0011 << {bus.mem_addr[1], 1'b0};
      end
      default: ;
    endcase
    if (bus.mem_rw != 2'b10) w_store_strb = 4'b0000;
  end

  // Load lane selection and extension from the latched address and size.
  always_comb begin
    case (r_p_addr[1:0])
      2'd0:    w_byte = bus.cache_read[7:0];
      2'd1:    w_byte = bus.cache_read[15:8];
      2'd2:    w_byte = bus.cache_read[23:16];
      default: w_byte = bus.cache_read[31:24];
    endcase
    w_half = r_p_addr[1] ? bus.cache_read[31:16] : bus.cache_read[15:0];
    case (r_size[1:0])
      2'b00:   w_load_data = {{24{w_byte[7] & ~r_size[2]}}, w_byte};
      2'b01:   w_load_data = {{16{w_half[15] & ~r_size[2]}}, w_half};
      default: w_load_data = bus.cache_read;
    endcase
  end

  // Cache request registers, response pulses and flush tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_last_ptw       <= 1'b1;
      r_drop           <= 1'b0;
      r_p_addr         <= '0;
      r_p_addr_valid   <= 1'b0;
      r_cache_rw       <= 2'b00;
      r_cache_write    <= '0;
      r_cache_wstrb    <= 4'b0000;
      r_size           <= 3'b000;
      r_mem_resp_valid <= 1'b0;
      r_mem_rdata      <= '0;
      r_ptw_resp_valid <= 1'b0;
      r_ptw_rdata      <= '0;
    end else begin
      r_mem_resp_valid <= 1'b0;
      r_ptw_resp_valid <= 1'b0;
      if (w_issue_mem) begin
        r_last_ptw     <= 1'b0;
        r_p_addr       <= bus.mem_addr;
        r_p_addr_valid <= 1'b1;
        r_cache_rw     <= bus.mem_rw;
        r_cache_write  <= w_store_data;
        r_cache_wstrb  <= w_store_strb;
        r_size         <= bus.mem_size;
      end else if (w_issue_ptw) begin
        r_last_ptw     <= 1'b1;
        r_p_addr       <= bus.ptw_addr;
        r_p_addr_valid <= 1'b1;
        r_cache_rw     <= 2'b01;
        r_cache_write  <= '0;
        r_cache_wstrb  <= 4'b0000;
      end else if (w_done) begin
        r_p_addr_valid <= 1'b0;
        r_cache_rw     <= 2'b00;
        if (r_state == S_MEM) begin
          if (!r_drop && !bus.mem_clear) begin
            r_mem_resp_valid <= 1'b1;
            if (r_cache_rw == 2'b01) r_mem_rdata <= w_load_data;
          end
        end else begin
          r_ptw_resp_valid <= 1'b1;
          r_ptw_rdata      <= bus.cache_read;
        end
      end
      if (r_state == S_MEM && w_done)             r_drop <= 1'b0;
      else if (r_state == S_MEM && bus.mem_clear) r_drop <= 1'b1;
    end
  end

  assign bus.mem_stall      = bus.mem_req_valid & w_mem_rw_ok & ~r_mem_resp_valid;
  assign bus.mem_resp_valid = r_mem_resp_valid;
  assign bus.mem_rdata      = r_mem_rdata;
  assign bus.ptw_resp_valid = r_ptw_resp_valid;
  assign bus.ptw_rdata      = r_ptw_rdata;
  assign bus.p_addr         = r_p_addr;
  assign bus.p_addr_valid   = r_p_addr_valid;
  assign bus.cache_rw       = r_cache_rw;
  assign bus.cache_write    = r_cache_write;
  assign bus.cache_wstrb    = r_cache_wstrb;

endmodule

// File: tb/tb_dcache_port_ctrl.sv
// tb/tb_dcache_port_ctrl.sv - directed and randomized bench for dcache_port_ctrl
module tb_dcache_port_ctrl;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  dcache_port_ctrl_if bus();
  dcache_port_ctrl dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [31:0] last_mem_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_req_valid = 1'b0; bus.mem_rw = 2'b00; bus.mem_addr = '0;
    bus.mem_wdata = '0; bus.mem_size = 3'b000; bus.mem_clear = 1'b0;
    bus.ptw_req_valid = 1'b0; bus.ptw_addr = '0;
    bus.cache_ready = 1'b0; bus.cache_read = '0;
  endtask

  task automatic mem_drive(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    bus.mem_req_valid = 1'b1; bus.mem_rw = rw; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_size = sz;
  endtask

  task automatic mem_release();
    bus.mem_req_valid = 1'b0; bus.mem_rw = 2'b00;
  endtask

  task automatic ptw_drive(input logic [31:0] a);
    bus.ptw_req_valid = 1'b1; bus.ptw_addr = a;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_pav"}, bus.p_addr_valid, 0);
    chk({tag, "_paddr"}, bus.p_addr, 0);
    chk({tag, "_rw"}, bus.cache_rw, 0);
    chk({tag, "_wr"}, bus.cache_write, 0);
    chk({tag, "_strb"}, bus.cache_wstrb, 0);
    chk({tag, "_mresp"}, bus.mem_resp_valid, 0);
    chk({tag, "_mrd"}, bus.mem_rdata, 0);
    chk({tag, "_presp"}, bus.ptw_resp_valid, 0);
    chk({tag, "_prd"}, bus.ptw_rdata, 0);
  endtask

  // Reference rules: store lane replication, byte enables, load extension.
  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [3:0] exp_strb(input logic [1:0] rw, input logic [1:0] sz, input logic [31:0] a);
    if (rw != 2'd2) return 4'h0;
    if (sz == 2'd0) return 4'(1 << (a % 4));
    if (sz == 2'd1) return 4'(3 << (((a / 2) % 2) * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] w);
    longint x;
    int nbits;
    int shift;
    if (sz[1:0] == 2'd0) begin nbits = 8;  shift = 8 * int'(a % 4); end
    else if (sz[1:0] == 2'd1) begin nbits = 16; shift = 16 * int'((a / 2) % 2); end
    else return w;
    x = w;
    x = (x >> shift) & ((longint'(1) << nbits) - 1);
    if (!sz[2] && x[nbits-1]) x = x - (longint'(1) << nbits);
    return x[31:0];
  endfunction

  initial begin
    rstn = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    // reset state
    check_all_zero("reset");
    chk("reset_stall", bus.mem_stall, 0);
    rstn = 1'b1;

    // zero-wait byte load with sign extension
    tick();
    mem_drive(2'b01, 32'h1003, 32'h0, 3'b000);
    #1;
    chk("lb_stall_n", bus.mem_stall, 1);
    tick();
    chk("lb_pav", bus.p_addr_valid, 1);
    chk("lb_paddr", bus.p_addr, 32'h1003);
    chk("lb_rw", bus.cache_rw, 2'b01);
    chk("lb_strb", bus.cache_wstrb, 0);
    chk("lb_stall_n1", bus.mem_stall, 1);
    bus.cache_ready = 1'b1; bus.cache_read = 32'h80FF_FF11;
    tick();
    chk("lb_resp", bus.mem_resp_valid, 1);
    chk("lb_rdata", bus.mem_rdata, 32'hFFFF_FF80);
    chk("lb_pav_done", bus.p_addr_valid, 0);
    chk("lb_stall_n2", bus.mem_stall, 0);
    bus.cache_ready = 1'b0;
    tick();
    chk("lb_no_regrant", bus.p_addr_valid, 0);
    chk("lb_resp_pulse", bus.mem_resp_valid, 0);
    chk("lb_rdata_hold", bus.mem_rdata, 32'hFFFF_FF80);
    mem_release();
    last_mem_rdata = 32'hFFFF_FF80;

    // half store held for four request cycles
    tick();
    mem_drive(2'b10, 32'h2002, 32'h0000_BEEF, 3'b001);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("sh_pav", bus.p_addr_valid, 1);
      chk("sh_paddr", bus.p_addr, 32'h2002);
      chk("sh_wr", bus.cache_write, 32'hBEEF_BEEF);
      chk("sh_strb", bus.cache_wstrb, 4'b1100);
      chk("sh_rw", bus.cache_rw, 2'b10);
      if (i == 3) bus.cache_ready = 1'b1;
    end
    tick();
    chk("sh_resp", bus.mem_resp_valid, 1);
    bus.cache_ready = 1'b0;
    mem_release();
    tick();
    chk("sh_idle", bus.p_addr_valid, 0);

    // simultaneous requests from reset alternate mem, ptw, mem
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    mem_drive(2'b01, 32'h3000, 32'h0, 3'b010);
    ptw_drive(32'h4000);
    tick();
    chk("rr1_paddr", bus.p_addr, 32'h3000);
    chk("rr1_pav", bus.p_addr_valid, 1);
    bus.cache_ready = 1'b1; bus.cache_read = 32'hAAAA_0001;
    tick();
    chk("rr1_resp", bus.mem_resp_valid, 1);
    chk("rr1_rdata", bus.mem_rdata, 32'hAAAA_0001);
    bus.cache_ready = 1'b0;
    tick();
    chk("rr2_paddr", bus.p_addr, 32'h4000);
    chk("rr2_rw", bus.cache_rw, 2'b01);
    bus.cache_ready = 1'b1; bus.cache_read = 32'hBBBB_0002;
    tick();
    chk("rr2_resp", bus.ptw_resp_valid, 1);
    chk("rr2_rdata", bus.ptw_rdata, 32'hBBBB_0002);
    bus.cache_ready = 1'b0;
    tick();
    chk("rr3_paddr", bus.p_addr, 32'h3000);
    chk("rr3_pav", bus.p_addr_valid, 1);
    bus.cache_ready = 1'b1; bus.cache_read = 32'hCCCC_0003;
    tick();
    chk("rr3_resp", bus.mem_resp_valid, 1);
    bus.cache_ready = 1'b0;
    mem_release();
    bus.ptw_req_valid = 1'b0;
    last_mem_rdata = 32'hCCCC_0003;
    tick();
    chk("rr_idle", bus.p_addr_valid, 0);

    // flush: blocked in IDLE, dropped response while in flight
    mem_drive(2'b01, 32'h5000, 32'h0, 3'b101);
    bus.mem_clear = 1'b1;
    tick();
    chk("fl_blocked", bus.p_addr_valid, 0);
    bus.mem_clear = 1'b0;
    tick();
    chk("fl_pav", bus.p_addr_valid, 1);
    chk("fl_paddr", bus.p_addr, 32'h5000);
    bus.mem_clear = 1'b1;
    tick();
    bus.mem_clear = 1'b0;
    chk("fl_inflight", bus.p_addr_valid, 1);
    tick();
    bus.cache_ready = 1'b1; bus.cache_read = 32'hDEAD_BEEF;
    tick();
    chk("fl_no_resp", bus.mem_resp_valid, 0);
    chk("fl_done", bus.p_addr_valid, 0);
    chk("fl_rdata_hold", bus.mem_rdata, last_mem_rdata);
    bus.cache_ready = 1'b0;
    mem_drive(2'b01, 32'h5006, 32'h0, 3'b001);
    tick();
    chk("fl_new_pav", bus.p_addr_valid, 1);
    chk("fl_new_paddr", bus.p_addr, 32'h5006);
    bus.cache_ready = 1'b1; bus.cache_read = 32'h8001_7FFF;
    tick();
    chk("fl_new_resp", bus.mem_resp_valid, 1);
    chk("fl_new_rdata", bus.mem_rdata, exp_load(3'b001, 32'h5006, 32'h8001_7FFF));
    bus.cache_ready = 1'b0;
    mem_release();
    tick();

    // walker read
    ptw_drive(32'h8000_0010);
    tick();
    chk("pt_paddr", bus.p_addr, 32'h8000_0010);
    chk("pt_rw", bus.cache_rw, 2'b01);
    chk("pt_strb", bus.cache_wstrb, 0);
    bus.cache_ready = 1'b1; bus.cache_read = 32'h1234_5678;
    tick();
    chk("pt_resp", bus.ptw_resp_valid, 1);
    chk("pt_rdata", bus.ptw_rdata, 32'h1234_5678);
    bus.cache_ready = 1'b0;
    tick();
    chk("pt_pulse", bus.ptw_resp_valid, 0);
    chk("pt_no_regrant", bus.p_addr_valid, 0);
    bus.ptw_req_valid = 1'b0;
    tick();
    chk("pt_rdata_hold", bus.ptw_rdata, 32'h1234_5678);

    // reset in the middle of a transaction
    mem_drive(2'b01, 32'h6001, 32'h0, 3'b100);
    tick();
    chk("rs_pav", bus.p_addr_valid, 1);
    #2 rstn = 1'b0;
    #1;
    check_all_zero("rs_mid");
    #2 rstn = 1'b1;
    tick();
    chk("rs_reissue_pav", bus.p_addr_valid, 1);
    chk("rs_reissue_paddr", bus.p_addr, 32'h6001);
    bus.cache_ready = 1'b1; bus.cache_read = 32'h0000_AB00;
    tick();
    chk("rs_resp", bus.mem_resp_valid, 1);
    chk("rs_rdata", bus.mem_rdata, 32'h0000_00AB);
    bus.cache_ready = 1'b0;
    mem_release();

    // randomized transactions against the rule-based model
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    begin
      int last_side;
      last_side = 1;
      for (int it = 0; it < 40; it++) begin
        int sel;
        int order[$];
        logic [1:0]  m_rw;
        logic [2:0]  m_sz;
        logic [31:0] m_addr, m_wdata, p_addr_m;
        bit mem_pending;
        sel = $urandom_range(0, 2);
        m_rw = 2'($urandom_range(1, 2));
        m_sz = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
        m_addr = $urandom;
        m_wdata = $urandom;
        p_addr_m = $urandom & 32'hFFFF_FFFC;
        mem_pending = (sel != 1);
        if (sel != 1) mem_drive(m_rw, m_addr, m_wdata, m_sz);
        if (sel != 0) ptw_drive(p_addr_m);
        order.delete();
        if (sel == 0) order.push_back(0);
        else if (sel == 1) order.push_back(1);
        else if (last_side == 1) begin order.push_back(0); order.push_back(1); end
        else begin order.push_back(1); order.push_back(0); end
        foreach (order[k]) begin
          int dly;
          logic [31:0] rd;
          dly = $urandom_range(0, 3);
          rd = $urandom;
          tick();
          chk("rnd_stall", bus.mem_stall, 32'(mem_pending));
          for (int d = 0; d <= dly; d++) begin
            chk("rnd_pav", bus.p_addr_valid, 1);
            if (order[k] == 0) begin
              chk("rnd_m_paddr", bus.p_addr, m_addr);
              chk("rnd_m_rw", bus.cache_rw, m_rw);
              chk("rnd_m_strb", bus.cache_wstrb, exp_strb(m_rw, m_sz[1:0], m_addr));
              if (m_rw == 2'd2) chk("rnd_m_wr", bus.cache_write, exp_wdata(m_sz[1:0], m_wdata));
            end else begin
              chk("rnd_p_paddr", bus.p_addr, p_addr_m);
              chk("rnd_p_rw", bus.cache_rw, 2'b01);
              chk("rnd_p_strb", bus.cache_wstrb, 0);
            end
            if (d == dly) begin
              bus.cache_ready = 1'b1;
              bus.cache_read = rd;
            end else begin
              tick();
            end
          end
          tick();
          bus.cache_ready = 1'b0;
          chk("rnd_mresp", bus.mem_resp_valid, 32'(order[k] == 0));
          chk("rnd_presp", bus.ptw_resp_valid, 32'(order[k] == 1));
          if (order[k] == 0) begin
            if (m_rw == 2'd1) chk("rnd_m_rdata", bus.mem_rdata, exp_load(m_sz, m_addr, rd));
            chk("rnd_m_stall_done", bus.mem_stall, 0);
            mem_release();
            mem_pending = 1'b0;
          end else begin
            chk("rnd_p_rdata", bus.ptw_rdata, rd);
            bus.ptw_req_valid = 1'b0;
          end
          last_side = order[k];
        end
        tick();
        chk("rnd_idle", bus.p_addr_valid, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
